// File: rtl/usb_event_scheduler.sv
// Edge-triggered event scheduler: latches rising edges per channel and offers them
// round-robin over a valid/ready handshake. Optional overflow flags: USB_EVT_OVERFLOW_EN.
module usb_event_scheduler #(
    parameter int N   = 5,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   signal,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   ovf,
    input  logic           ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t         state, state_n;
    logic [N-1:0]   sig_d1, sig_d2;
    logic [N-1:0]   rise, clr_mask, merge;
    logic [N-1:0]   pending_q, pending_n;
    logic [IDW-1:0] rr_ptr, rr_ptr_n;
    logic [IDW-1:0] evt_id_q, evt_id_n;
    logic [IDW-1:0] pick;
    logic           found;
    logic           handshake;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N) j = j - N;
        return IDW'(j);
    endfunction

    assign rise      = sig_d1 & ~sig_d2;
    assign handshake = (state == OFFER) && evt_ready;
    assign clr_mask  = handshake ? (N'(1) << evt_id_q) : '0;
    // A rise in the handshake cycle re-arms the bit rather than being lost.
    assign pending_n = (pending_q & ~clr_mask) | rise;
    assign merge     = rise & pending_q & ~clr_mask;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && pending_q[wrap_idx(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_n  = state;
        evt_id_n = evt_id_q;
        rr_ptr_n = rr_ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    evt_id_n = pick;
                    state_n  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    rr_ptr_n = (evt_id_q == IDW'(N - 1)) ? '0 : evt_id_q + 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sig_d1    <= '0;
            sig_d2    <= '0;
            pending_q <= '0;
            rr_ptr    <= '0;
            evt_id_q  <= '0;
        end else begin
            state     <= state_n;
            sig_d1    <= signal;
            sig_d2    <= sig_d1;
            pending_q <= pending_n;
            rr_ptr    <= rr_ptr_n;
            evt_id_q  <= evt_id_n;
        end
    end

    assign evt_valid = (state == OFFER);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;

`ifdef USB_EVT_OVERFLOW_EN
    logic [N-1:0] ovf_q;

    // A new merge on a bit wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= (ovf_clr ? '0 : ovf_q) | merge;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr | (|merge);
    assign ovf        = '0;
`endif

endmodule

// File: tb/tb_usb_event_scheduler.sv
// Directed bench for usb_event_scheduler (N=5): edge detect, round-robin, backpressure,
// handshake collision, overflow flags and asynchronous reset.
module tb_usb_event_scheduler;

    localparam int N   = 5;
    localparam int IDW = 3;
`ifdef USB_EVT_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   signal;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_ready;
    logic [N-1:0]   pending;
    logic [N-1:0]   ovf;
    logic           ovf_clr;

    int vectors     = 0;
    int miscompares = 0;

    usb_event_scheduler #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal    (signal),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_offer(input string tag, input logic [IDW-1:0] id);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_id"}, 32'(evt_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; signal = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        step(2);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Single edge on ch2
        signal = 5'b00100; evt_ready = 1'b1;
        step(); chk("t1_lat1_valid", 32'(evt_valid), 32'd0);
        step(); chk("t1_pend", 32'(pending), 32'h04);
        chk("t1_lat2_valid", 32'(evt_valid), 32'd0);
        step(); chk_offer("t1_offer", 3'd2);
        step(); chk("t1_hs_valid", 32'(evt_valid), 32'd0);
        chk("t1_hs_pend", 32'(pending), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("t1_no_second", 32'(evt_valid), 32'd0);
        end
        signal = '0; step(3);

        // Round-robin from rr_ptr=0
        rst_n = 1'b0; step(); rst_n = 1'b1;
        signal = 5'b10011;
        step(2); chk("t2_pend", 32'(pending), 32'h13);
        step(); chk_offer("t2_o0", 3'd0);
        step(); chk("t2_gap0", 32'(evt_valid), 32'd0);
        chk("t2_pend0", 32'(pending), 32'h12);
        step(); chk_offer("t2_o1", 3'd1);
        step(); chk("t2_gap1", 32'(evt_valid), 32'd0);
        step(); chk_offer("t2_o4", 3'd4);
        step(); chk("t2_pend_end", 32'(pending), 32'd0);
        signal = '0; step(3);
        chk("t2_idle", 32'(evt_valid), 32'd0);
        // Serve ch1 to move rr_ptr to 2, then ch0 and ch3 together
        signal = 5'b00010;
        step(3); chk_offer("t2_o1b", 3'd1);
        step();
        signal = 5'b01011;
        step(2); chk("t2_pend03", 32'(pending), 32'h09);
        step(); chk_offer("t2_o3", 3'd3);
        step(2); chk_offer("t2_o0b", 3'd0);
        step(); chk("t2_done", 32'(pending), 32'd0);
        signal = '0; step(3);

        // Backpressure on ch1 with ch3 arriving meanwhile
        evt_ready = 1'b0;
        signal = 5'b00010;
        step(3); chk_offer("t3_offer", 3'd1);
        signal = 5'b01010;
        for (int i = 0; i < 10; i++) begin
            step(); chk_offer("t3_hold", 3'd1);
        end
        chk("t3_pend", 32'(pending), 32'h0A);
        evt_ready = 1'b1;
        step(); chk("t3_hs_valid", 32'(evt_valid), 32'd0);
        chk("t3_hs_pend", 32'(pending), 32'h08);
        step(); chk_offer("t3_o3", 3'd3);
        step(); chk("t3_pend_end", 32'(pending), 32'd0);
        chk("t3_ovf", 32'(ovf), 32'd0);
        signal = '0; step(3);

        // Rise on ch1 in the same cycle as its handshake
        evt_ready = 1'b0;
        signal = 5'b00010;
        step(3); chk_offer("t4_offer", 3'd1);
        signal = '0;
        step(2);
        signal = 5'b00010;
        step();
        evt_ready = 1'b1;
        step(); chk("t4_hs_valid", 32'(evt_valid), 32'd0);
        chk("t4_keep_pend", 32'(pending), 32'h02);
        step(); chk_offer("t4_again", 3'd1);
        step(); chk("t4_pend_end", 32'(pending), 32'd0);
        chk("t4_ovf", 32'(ovf), 32'd0);

        // Overflow: second ch0 edge while ch0 is blocked
        evt_ready = 1'b0;
        signal = '0; step(2);
        signal = 5'b00001;
        step(3); chk_offer("t5_offer", 3'd0);
        signal = '0; step(2);
        signal = 5'b00001; step(2);
        chk("t5_merge_pend", 32'(pending), 32'h01);
        chk("t5_ovf_set", 32'(ovf), OVF_EN ? 32'h01 : 32'h00);
        ovf_clr = 1'b1; signal = '0;
        step(); chk("t5_ovf_clr", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
        step();
        signal = 5'b00001;
        step();
        ovf_clr = 1'b1;
        step(); chk("t5_set_wins", 32'(ovf), OVF_EN ? 32'h01 : 32'h00);
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        step(); chk("t5_hs_valid", 32'(evt_valid), 32'd0);
        chk("t5_pend_end", 32'(pending), 32'd0);

        // Asynchronous reset in the middle of an offer
        evt_ready = 1'b0;
        signal = '0; step(2);
        signal = 5'b00100;
        step(3); chk_offer("t6_offer", 3'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        chk("t6_rst_id", 32'(evt_id), 32'd0);
        chk("t6_rst_ovf", 32'(ovf), 32'd0);
        step();
        rst_n = 1'b1;
        step(2); chk("t6_pend", 32'(pending), 32'h04);
        step(); chk_offer("t6_reoffer", 3'd2);
        evt_ready = 1'b1;
        step(); chk("t6_hs", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(); chk("t6_only_one", 32'(evt_valid), 32'd0);
        end
        chk("t6_pend_end", 32'(pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
